// File: rtl/shared_ram_arbiter_if.sv
// Signal bundle linking the CPU requester, the video fetcher and the shared RAM
// to the arbiter; the arbiter connects through the slave modport.
interface shared_ram_arbiter_if;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  logic          cpu_req;
  logic          cpu_we;
  logic [BW-1:0] cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_dtack_n;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_valid;
  logic [DW-1:0] vid_data;

  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr,
    input  ram_rdata,
    output cpu_rdata, cpu_dtack_n,
    output vid_ack, vid_valid, vid_data,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output vid_req, vid_addr,
    output ram_rdata,
    input  cpu_rdata, cpu_dtack_n,
    input  vid_ack, vid_valid, vid_data,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/shared_ram_arbiter.sv
// Shares one single-port RAM between a 16-bit CPU bus (dtack handshake) and a
// pipelined video fetcher; video has priority until the CPU has lost STARVE_LIMIT times.
module shared_ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  shared_ram_arbiter_if.slave  bus
);
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    CPU_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_cpu_wr_p1;
  logic          r_cpu_rd_p1;
  logic          r_cpu_rd_p2;
  logic          r_vid_ack;
  logic          r_vid_valid;
  logic          r_dtack_n;
  logic [AW-1:0] r_ram_addr;
  logic [BW-1:0] r_ram_we;
  logic [DW-1:0] r_ram_wdata;
  logic [DW-1:0] r_cpu_rdata;

  logic w_cpu_elig;
  logic w_starved;
  logic w_cpu_grant;
  logic w_vid_grant;
  logic w_abort;
  logic w_done;

  // Arbitration: the CPU can only compete while no CPU cycle is outstanding.
  assign w_cpu_elig  = (r_state == IDLE) && bus.cpu_req;
  assign w_starved   = r_starve_cnt >= CW'(STARVE_LIMIT);
  assign w_cpu_grant = w_cpu_elig && (!bus.vid_req || w_starved);
  assign w_vid_grant = bus.vid_req && !w_cpu_grant;
  assign w_abort     = (r_state == CPU_WAIT) && !bus.cpu_req;
  assign w_done      = r_cpu_wr_p1 || r_cpu_rd_p2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_cpu_wr_p1  <= 1'b0;
      r_cpu_rd_p1  <= 1'b0;
      r_cpu_rd_p2  <= 1'b0;
      r_vid_ack    <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_dtack_n    <= 1'b1;
      r_ram_addr   <= '0;
      r_ram_we     <= '0;
      r_ram_wdata  <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      r_vid_ack   <= w_vid_grant;
      r_vid_valid <= r_vid_ack;
      r_cpu_wr_p1 <= w_cpu_grant && bus.cpu_we;
      r_cpu_rd_p1 <= w_cpu_grant && !bus.cpu_we;
      // An aborted read still completes on the RAM but never reaches the CPU.
      r_cpu_rd_p2 <= r_cpu_rd_p1 && !w_abort;
      r_ram_we    <= '0;

      if (w_vid_grant) begin
        r_ram_addr <= bus.vid_addr;
      end else if (w_cpu_grant) begin
        r_ram_addr  <= bus.cpu_addr;
        r_ram_wdata <= bus.cpu_wdata;
        r_ram_we    <= bus.cpu_we ? bus.cpu_be : '0;
      end

      if (w_cpu_grant) begin
        r_starve_cnt <= '0;
      end else if (w_cpu_elig && w_vid_grant && (r_starve_cnt != '1)) begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_cpu_grant) r_state <= CPU_WAIT;
        end
        CPU_WAIT: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (w_done) begin
            r_state   <= CPU_HOLD;
            r_dtack_n <= 1'b0;
            if (r_cpu_rd_p2) r_cpu_rdata <= bus.ram_rdata;
          end
        end
        CPU_HOLD: begin
          if (!bus.cpu_req) begin
            r_state   <= IDLE;
            r_dtack_n <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.cpu_dtack_n = r_dtack_n;
  assign bus.vid_ack     = r_vid_ack;
  assign bus.vid_valid   = r_vid_valid;
  // RAM read data arrives in the vid_valid cycle, so it is forwarded directly.
  assign bus.vid_data    = bus.ram_rdata;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_wdata   = r_ram_wdata;
endmodule
